// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
// Holds the fetch FSM state encoding and the address / instruction widths.
// Imported by fetch_unit; contains no logic.
package fetch_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a synchronous-read instruction
// memory and presents {instr, instr_pc} to decode, one instruction per cycle.
// Latency: 1 cycle address-to-instr_valid; stall re-reads the outstanding
// address, redirect retargets with zero bubble and wins over stall.
// Ports: clk/reset (sync, active-high); imem_a/imem_rd memory side; stall,
// redirect, redirect_pc from decode/execute; instr, instr_pc, instr_valid,
// fetch_fault, fetch_count towards decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int unsigned       MEM_SIZE = 1450
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_a,
  input  logic [INSTR_W-1:0] imem_rd,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic               fetch_fault,
  output logic [31:0]        fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] f_pc_q, f_pc_d;
  logic              f_valid_q, f_valid_d;
  logic [31:0]       count_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < MEM_SIZE;
  endfunction

  // An instruction is consumed only when shown, not stalled and not killed.
  logic accept;
  assign accept = instr_valid && !stall && !redirect;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    f_pc_d    = f_pc_q;
    f_valid_d = f_valid_q;
    imem_a    = pc_q;

    unique case (state_q)
      ST_BOOT: begin
        imem_a = RESET_PC;
        if (in_range(RESET_PC)) begin
          f_pc_d    = RESET_PC;
          f_valid_d = 1'b1;
          pc_d      = RESET_PC + 16'd1;
          state_d   = ST_RUN;
        end else begin
          f_valid_d = 1'b0;
          state_d   = ST_HALT;
        end
      end

      ST_RUN: begin
        if (redirect) begin
          if (in_range(redirect_pc)) begin
            imem_a    = redirect_pc;
            f_pc_d    = redirect_pc;
            f_valid_d = 1'b1;
            pc_d      = redirect_pc + 16'd1;
          end else begin
            imem_a    = f_pc_q;
            f_valid_d = 1'b0;
            state_d   = ST_HALT;
          end
        end else if (stall) begin
          // Re-issue the outstanding address so imem_rd stays put next cycle.
          imem_a = f_pc_q;
        end else if (in_range(pc_q)) begin
          imem_a    = pc_q;
          f_pc_d    = pc_q;
          f_valid_d = 1'b1;
          pc_d      = pc_q + 16'd1;
        end else begin
          imem_a    = f_pc_q;
          f_valid_d = 1'b0;
          state_d   = ST_HALT;
        end
      end

      ST_HALT: begin
        // Only an in-range redirect restarts fetch; everything else is ignored.
        if (redirect && in_range(redirect_pc)) begin
          imem_a    = redirect_pc;
          f_pc_d    = redirect_pc;
          f_valid_d = 1'b1;
          pc_d      = redirect_pc + 16'd1;
          state_d   = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // While reset is held the memory is pointed at the boot address.
    if (reset) begin
      imem_a = RESET_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      f_pc_q    <= RESET_PC;
      f_valid_q <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      f_pc_q    <= f_pc_d;
      f_valid_q <= f_valid_d;
      if (accept) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign instr       = imem_rd;
  assign instr_pc    = f_pc_q;
  assign instr_valid = f_valid_q && (state_q == ST_RUN);
  assign fetch_fault = (state_q == ST_HALT);
  assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: owns the program counter, drives the word address of the synchronous-read instruction memory, which returns data one cycle after the address edge, and presents fetched instructions with their PCs to decode. It absorbs decode back-pressure by re-reading the outstanding address, and applies branch/jump redirects with zero bubble. It stops cleanly and flags a fault when the PC leaves the populated memory range.

## Interface
- `RESET_PC`, 16'h0000 — first word address fetched after reset.
- `MEM_SIZE`, 1450 — number of valid instruction words. Addresses `>= MEM_SIZE` are out of range.
- `clk`  in  1  — single clock, all state on posedge.
- `reset`  in  1  — synchronous, active-high.
- `imem_a`  out  16  — word address to instruction memory, sampled by memory on posedge.
- `imem_rd`  in  32  — memory data; equals RAM[address sampled at previous edge].
- `stall`  in  1  — decode cannot accept the presented instruction this cycle.
- `redirect`  in  1  — taken branch/jump; kills the presented instruction.
- `redirect_pc`  in  16  — target word address, valid with `redirect`.
- `instr`  out  32  — presented instruction (= `imem_rd`).
- `instr_pc`  out  16  — word address of `instr`.
- `instr_valid`  out  1  — `instr`/`instr_pc` meaningful.
- `fetch_fault`  out  1  — PC out of range; fetch halted.
- `fetch_count`  out  32  — instructions accepted by decode since reset.

## Operation
- Registers:
  - `pc`: next address to issue.
  - `f_pc`, `f_valid`: address issued at the last edge; its data is on `imem_rd` now.
  - FSM state.
  - `fetch_count`.
- FSM states: BOOT, RUN, HALT.
- Accept: cycle with `instr_valid && !stall && !redirect`; `fetch_count` increments by 1, wrapping at 2^32.
- BOOT (entered by reset):
  - `imem_a = RESET_PC`.
  - Next edge: `f_pc <= RESET_PC`, `f_valid <= 1`, `pc <= RESET_PC+1`, go RUN.
  - If `RESET_PC >= MEM_SIZE`, go HALT instead, with `f_valid <= 0`.
- RUN, priority redirect > stall > advance:
  - redirect, in range:
    - `imem_a = redirect_pc`.
    - `f_pc <= redirect_pc`, `f_valid <= 1`, `pc <= redirect_pc+1`.
    - Current instruction dropped, not counted.
  - redirect, out of range: `f_valid <= 0`, go HALT.
  - stall (no redirect):
    - `imem_a = f_pc` (re-read, so `imem_rd` is unchanged next cycle).
    - `pc`, `f_pc`, `f_valid` hold.
  - advance:
    - If `pc < MEM_SIZE`: `imem_a = pc`, `f_pc <= pc`, `f_valid <= 1`, `pc <= pc+1`.
    - Else: `imem_a = f_pc`, `f_valid <= 0`, go HALT.
- HALT:
  - `fetch_fault = 1`, `instr_valid = 0`, `imem_a = pc`.
  - In-range `redirect` behaves as in RUN and returns to RUN.
  - Out-of-range redirect and stall are ignored.
- `pc` arithmetic is 16-bit unsigned. The range check (`< MEM_SIZE`) is done before increment, so wrap from 16'hFFFF is unreachable while `MEM_SIZE <= 65535`.
- Outputs:
  - `instr_valid = f_valid && state==RUN`.
  - `instr = imem_rd`, `instr_pc = f_pc`.
  - `imem_a` is combinational from state, `redirect`, `redirect_pc`, `stall`.

## Timing
- Reset values: state BOOT, `pc = RESET_PC`, `f_pc = RESET_PC`, `f_valid = 0`, `fetch_count = 0`.
- Outputs during reset and in BOOT: `instr_valid = 0`, `fetch_fault = 0`, `imem_a = RESET_PC`.
- First valid instruction: first cycle after the BOOT edge.
- Fetch latency 1 cycle, address edge to `instr_valid`. Throughput 1 instruction/cycle with no stall.
- Redirect at cycle k: the target instruction is valid at k+1; no bubble.
- Stall held N cycles: `instr`/`instr_pc` stay stable for all N cycles; the next instruction appears the cycle after `stall` drops.
- Reset mid-stream overrides everything: outputs reach reset values on the reset edge; in-flight fetch is discarded.
- `stall && redirect`: redirect wins.
- Combinational paths `stall`/`redirect` → `imem_a` are accepted. No path from inputs to `instr_valid`.

## Structure
- Shared package `fetch_pkg`:
  - FSM state enum (BOOT/RUN/HALT).
  - Word-address width constant (16).
  - Instruction width constant (32).
- No sub-module. Single module, with an address mux, one FSM, and the counter.

## Test plan
- Reset, `RESET_PC=0`, memory word n = n, no stall → `instr_valid` rises the cycle after BOOT; `instr_pc`=0,1,2,3 on consecutive cycles; `instr`=0,1,2,3.
- Stall asserted 3 cycles while `instr_pc=5` → `instr_pc=5` and `instr=5` held for 3 cycles; `instr_pc=6` the cycle after release; `fetch_count` increments once for pc 5.
- `redirect`, `redirect_pc=100`, while presenting pc 7 → next cycle `instr_pc=100`, `instr=100`; pc 7 not counted.
- Redirect and stall asserted in the same cycle → redirect behaviour exactly as the previous scenario.
- `MEM_SIZE=10`, free run → last valid `instr_pc=9`; then `instr_valid=0`, `fetch_fault=1`; redirect to 2 clears the fault and `instr_pc=2` is valid next cycle.
- Reset pulsed while streaming at pc 40 → next cycle all outputs at reset values; `fetch_count=0`; restarts at `RESET_PC`.
